// File: rtl/crypto_seq_pkg.sv
// ============================================================================
// Module      : crypto_seq_pkg
// Description : Shared types and constants for the AES round sequencer.
//               Holds the sequencer state encoding, the key-length encoding,
//               the per-key-length round counts, and the helpers that decode
//               a key length into legality and round count.
// Config      : AES256_EN - when defined, key length 2'b10 (AES-256) is a
//               legal 14-round job; otherwise it is rejected.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crypto_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    KEY_128  = 2'b00,
    KEY_192  = 2'b01,
    KEY_256  = 2'b10,
    KEY_RSVD = 2'b11
  } key_len_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // A key length is legal only if this build can run it.
  function automatic logic key_len_legal(input key_len_t kl);
    case (kl)
      KEY_128, KEY_192: return 1'b1;
`ifdef AES256_EN
      KEY_256:          return 1'b1;
`endif
      default:          return 1'b0;
    endcase
  endfunction

  // Round count for a key length. Illegal lengths never reach the counter,
  // so their value here is irrelevant.
  function automatic int nr_of(input key_len_t kl);
    case (kl)
      KEY_192: return NR_192;
`ifdef AES256_EN
      KEY_256: return NR_256;
`endif
      default: return NR_128;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_step_counter.sv
// ============================================================================
// Module      : aes_step_counter
// Description : Step position tracker for one AES block operation. Holds the
//               round index and the key/round phase, counting up for encrypt
//               (0, then key/round pairs 1..NR) and down for decrypt (NR..0).
// Ports       : clk, reset (async, active low)
//               i_load      - start a job: capture direction and NR
//               i_decrypt   - direction for the load (1 = count down)
//               i_nr        - round count for the load
//               i_advance   - move to the next step
//               o_round     - round index of the current step
//               o_key_assist- current step is a key-expansion step
//               o_last_step - current step is the final round step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_step_counter #(
  parameter int NR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_decrypt,
  input  logic [NR_W-1:0] i_nr,
  input  logic            i_advance,
  output logic [NR_W-1:0] o_round,
  output logic            o_key_assist,
  output logic            o_last_step
);

  logic [NR_W-1:0] r_round;
  logic [NR_W-1:0] r_nr;
  logic            r_key;
  logic            r_down;
  logic            w_last;

  // Terminal values are compared explicitly so the counter never wraps.
  assign w_last = r_down ? (r_round == '0)
                         : ((r_round == r_nr) && !r_key);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_round <= '0;
      r_nr    <= '0;
      r_key   <= 1'b0;
      r_down  <= 1'b0;
    end else if (i_load) begin
      r_down  <= i_decrypt;
      r_nr    <= i_nr;
      r_round <= i_decrypt ? i_nr : '0;
      r_key   <= 1'b0;
    end else if (i_advance && !w_last) begin
      if (r_down) begin
        r_round <= r_round - NR_W'(1);
      end else if (r_key) begin
        // Key step of round r is followed by the round step of round r.
        r_key <= 1'b0;
      end else begin
        r_round <= r_round + NR_W'(1);
        r_key   <= 1'b1;
      end
    end
  end

  assign o_round      = r_round;
  assign o_key_assist = r_key;
  assign o_last_step  = w_last;

endmodule

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ============================================================================
// Module      : aes_round_sequencer
// Description : Control FSM that walks the EXEC datapath through one full AES
//               block operation (whitening, key-assist and round steps) per
//               accepted job, and reports completion on a response channel.
// Ports       : clk, reset (async, active low)
//               req_valid/req_ready, req_decrypt, req_key_len - job request
//               abort                  - cancel the job in ISSUE/WAIT
//               exec_go, exec_key_assist, exec_encryption, exec_final_round,
//               exec_round, exec_done  - EXEC step control / completion
//               resp_valid/resp_ready, resp_error - job response
//               busy                   - any state other than IDLE
// Config      : AES256_EN - enables 14-round AES-256 jobs (key length 2'b10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int NR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_decrypt,
  input  logic [1:0]      req_key_len,
  input  logic            abort,
  output logic            exec_go,
  output logic            exec_key_assist,
  output logic            exec_encryption,
  output logic            exec_final_round,
  output logic [NR_W-1:0] exec_round,
  input  logic            exec_done,
  output logic            resp_valid,
  output logic            resp_error,
  input  logic            resp_ready,
  output logic            busy
);

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic            r_alive;
  logic            r_encrypt;
  logic            r_error;
  logic            w_cap;
  logic            w_load;
  logic            w_advance;
  logic            w_legal;
  logic            w_active;
  logic [NR_W-1:0] w_nr;
  logic [NR_W-1:0] w_round;
  logic            w_key_assist;
  logic            w_last_step;

  assign w_legal = key_len_legal(key_len_t'(req_key_len));
  assign w_nr    = NR_W'(nr_of(key_len_t'(req_key_len)));

  aes_step_counter #(
    .NR_W (NR_W)
  ) u_step_counter (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_decrypt    (req_decrypt),
    .i_nr         (w_nr),
    .i_advance    (w_advance),
    .o_round      (w_round),
    .o_key_assist (w_key_assist),
    .o_last_step  (w_last_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        // r_alive keeps req_ready low until the first edge after reset.
        if (r_alive && req_valid) begin
          w_cap = 1'b1;
          if (w_legal) begin
            w_load      = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      ISSUE: begin
        w_state_nxt = abort ? IDLE : WAIT;
      end
      WAIT: begin
        // Abort outranks a completion sampled in the same cycle.
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (exec_done) begin
          if (w_last_step) begin
            w_state_nxt = RESP;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_alive   <= 1'b0;
      r_encrypt <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      if (w_cap) begin
        r_encrypt <= ~req_decrypt;
        r_error   <= ~w_legal;
      end
    end
  end

  // Step controls are only meaningful while a step is in flight; forcing
  // them low elsewhere also keeps them at zero during reset.
  assign w_active         = (r_state == ISSUE) || (r_state == WAIT);
  assign req_ready        = r_alive && (r_state == IDLE);
  assign exec_go          = (r_state == ISSUE);
  assign exec_key_assist  = w_active && w_key_assist;
  assign exec_final_round = w_active && w_last_step;
  assign exec_round       = w_active ? w_round : '0;
  assign exec_encryption  = r_encrypt;
  assign resp_valid       = (r_state == RESP);
  assign resp_error       = (r_state == RESP) && r_error;
  assign busy             = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that sequences the EXEC datapath through a complete AES block operation: the whitening step, key-assist steps and round steps, with the final-round flag on the last step. It accepts one job at a time over a valid/ready request channel and drives EXEC's `keyAssist`, `encryption` and `finalRound` controls plus the round index. It waits for EXEC completion on each step and reports over a valid/ready response channel. It sits between the instruction front end (or a host DMA) and EXEC, replacing per-round instruction issue for bulk AES.

## Interface
- `NR_W`, default 4: width of the round counter.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: job request present.
- `req_ready`, output, 1: sequencer idle and able to accept a job.
- `req_decrypt`, input, 1: 1 = decrypt job, 0 = encrypt job.
- `req_key_len`, input, 2: key length; 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- `abort`, input, 1: synchronous cancel of the current job.
- `exec_go`, output, 1: one-cycle pulse that starts one EXEC step.
- `exec_key_assist`, output, 1: current step is a key-expansion step.
- `exec_encryption`, output, 1: the inverse of the captured `req_decrypt`.
- `exec_final_round`, output, 1: current step is the last round step.
- `exec_round`, output, NR_W: round index of the current step.
- `exec_done`, input, 1: EXEC has finished the step that was issued.
- `resp_valid`, output, 1: job finished.
- `resp_error`, output, 1: job rejected; qualified by `resp_valid`.
- `resp_ready`, input, 1: consumer accepts the response.
- `busy`, output, 1: a job is in flight (any state other than IDLE).

## Operation
- **Number of rounds (NR):** 10, 12 or 14, selected by the captured `req_key_len`.
- **Encrypt step order:**
  - Whitening step: round 0, key_assist = 0.
  - Then for r = 1..NR: a key step (round r, key_assist = 1), followed by a round step (round r, key_assist = 0).
  - Total 1 + 2·NR steps.
- **Decrypt step order:**
  - Whitening step at round NR.
  - Then round steps for r = NR−1 down to 0.
  - No key steps; round keys are already resident from a prior encrypt job.
  - Total 1 + NR steps.
- **`exec_final_round`:** 1 only on the last round step (encrypt round NR, decrypt round 0).
- **States:**
  - IDLE: `req_ready` = 1. On `req_valid` && `req_ready`, capture `req_decrypt` and `req_key_len`. Go to ISSUE, or to RESP with the error flag set if the key length is illegal.
  - ISSUE: `exec_go` = 1 for exactly one cycle; go to WAIT.
  - WAIT: hold all exec_* controls stable. When `exec_done` is sampled: if more steps remain, advance the step counter and go to ISSUE; otherwise go to RESP.
  - RESP: `resp_valid` = 1, held until `resp_ready`; then go to IDLE.
- **`exec_done` handling:** ignored outside WAIT. It is never sampled in the same cycle as `exec_go`.
- **Abort:** `abort` in ISSUE or WAIT returns to IDLE on the next edge. No response is produced and `exec_go` is not reissued. In IDLE or RESP, `abort` has no effect.
- **Priority:** if `abort` and `exec_done` are both sampled in WAIT, abort wins.
- **Illegal key length:** 11 is always illegal (see Configuration for 10). An illegal job produces no `exec_go`; `resp_valid` = 1 and `resp_error` = 1 in the cycle after acceptance.
- **Counter wrap:** the step counter never wraps; its terminal value is compared explicitly.

## Timing
- **Reset values:** while `reset` = 0, all outputs are 0, including `req_ready`. State is IDLE and the counters are 0.
- **After reset release:** `req_ready` = 1 on the first rising edge after `reset` deasserts.
- **Output timing:** all outputs are registered or decoded from state. There is no combinational path from any input to any output.
- **Accept-to-first-step latency:** the job is accepted at edge 0 and `exec_go` is high in cycle 1.
- **Best-case cadence:** with `exec_done` arriving the cycle after each go, one step takes 2 cycles.
  - AES-128 encrypt: `resp_valid` in cycle 43.
  - AES-128 decrypt: `resp_valid` in cycle 23.
- **Back-to-back jobs:** a new job can be accepted in the cycle after the response handshake.
- **Asynchronous reset mid-job:** everything returns immediately to its reset values, and `exec_go` drops in the same instant.

## Configuration
- **`AES256_EN` defined:** `req_key_len` = 10 runs a 14-round job.
- **`AES256_EN` undefined:**
  - `req_key_len` = 10 is treated as illegal (error response).
  - Round-count decode logic for 14 is removed.
  - `NR_W` of 4 is still sufficient.

## Structure
- **Package `crypto_seq_pkg`:**
  - `seq_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `key_len_t` enum.
  - Constants NR_128 = 10, NR_192 = 12, NR_256 = 14.
  - A function mapping key length to NR.
- **Sub-module `aes_step_counter`:**
  - Holds the round index and key/round phase.
  - Supports up-count and down-count modes.
  - Has load, advance and last-step outputs.
- **Top level:** the FSM plus the capture registers.

## Test plan
- **AES-128 encrypt:** `exec_done` one cycle after each go → 21 `exec_go` pulses; rounds 0,1,1,2,2,…,10,10; key_assist alternating from the second step; `exec_final_round` only on the 21st step; `resp_valid` in cycle 43, `resp_error` = 0.
- **AES-192 decrypt:** `exec_done` delayed 3 cycles → 13 steps with rounds 12 down to 0; key_assist never set; `exec_encryption` = 0 throughout.
- **`req_key_len` = 11, or 10 with `AES256_EN` undefined:** no `exec_go`; `resp_valid` = 1 and `resp_error` = 1 in cycle 1.
- **Abort in WAIT of step 5, with `exec_done` also high that cycle:** return to IDLE; no further `exec_go`; no `resp_valid`; `req_ready` = 1 on the next cycle.
- **`reset` pulled low mid-WAIT:** all outputs 0 immediately; a fresh job after release runs cleanly from round 0.
- **`resp_ready` held low for 5 cycles:** `resp_valid` stays high and `req_ready` stays 0; a new job is accepted the cycle after the handshake.
